// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: deserialises data bits, checks optional parity and STOP_BITS stop bits.
// Define UART_BRK_DET_EN to compile in break detection; otherwise brk_det is tied to 0.
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  frm_start,
   input  logic                  bit_vld,
   input  logic                  sampled_bit,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_vld,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  brk_det,
   output logic                  busy,
   output logic [1:0]            state_dbg
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] sh;
   logic                  par_run, par_bad, stp_bad, stp_cnt;
   logic                  par_en_l, par_typ_l;
   logic                  commit, last_data, last_stop;

   assign last_data = (cnt == CW'(DATA_WIDTH - 1));
   assign last_stop = (stp_cnt == 1'(STOP_BITS - 1));
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // frm_start wins over bit_vld in every state, which also aborts a frame in progress.
   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      if (frm_start) begin
         state_nxt = DATA;
      end else if (bit_vld) begin
         case (state)
            DATA:    if (last_data) state_nxt = par_en_l ? PAR : STOP;
            PAR:     state_nxt = STOP;
            STOP: begin
               if (last_stop) begin
                  state_nxt = IDLE;
                  commit    = 1'b1;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt       <= '0;
         sh        <= '0;
         par_run   <= 1'b0;
         par_bad   <= 1'b0;
         stp_bad   <= 1'b0;
         stp_cnt   <= 1'b0;
         par_en_l  <= 1'b0;
         par_typ_l <= 1'b0;
         data_out  <= '0;
         data_vld  <= 1'b0;
         par_err   <= 1'b0;
         stp_err   <= 1'b0;
      end else begin
         data_vld <= 1'b0;
         if (frm_start) begin
            par_en_l  <= par_en;
            par_typ_l <= par_typ;
            cnt       <= '0;
            sh        <= '0;
            par_run   <= 1'b0;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
            stp_cnt   <= 1'b0;
         end else if (bit_vld) begin
            case (state)
               DATA: begin
                  sh      <= {sampled_bit, sh[DATA_WIDTH-1:1]};
                  par_run <= par_run ^ sampled_bit;
                  cnt     <= cnt + CW'(1);
               end
               PAR: par_bad <= par_run ^ sampled_bit ^ par_typ_l;
               STOP: begin
                  stp_bad <= stp_bad | ~sampled_bit;
                  stp_cnt <= stp_cnt + 1'b1;
                  if (commit) begin
                     data_out <= sh;
                     data_vld <= 1'b1;
                     par_err  <= par_en_l & par_bad;
                     stp_err  <= stp_bad | ~sampled_bit;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef UART_BRK_DET_EN
   logic nz, stop0_zero;

   // nz remembers any 1 seen in data or parity; stop0_zero holds the first stop bit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         nz         <= 1'b0;
         stop0_zero <= 1'b0;
         brk_det    <= 1'b0;
      end else if (frm_start) begin
         nz         <= 1'b0;
         stop0_zero <= 1'b0;
      end else if (bit_vld) begin
         if (state == DATA || state == PAR) nz <= nz | sampled_bit;
         if (state == STOP && stp_cnt == 1'b0) stop0_zero <= ~sampled_bit;
         if (commit)
            brk_det <= ~nz & ((stp_cnt == 1'b0) ? ~sampled_bit : stop0_zero);
      end
   end
`else
   assign brk_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check: three instances (8/1, 8/2, 5/1) driven from one sequence.
module tb_uart_rx_frame_check;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic fs [3];
   logic bv [3];
   logic sb = 1'b0, pen = 1'b0, ptyp = 1'b0;

   logic [7:0] d8a, d8b;
   logic [4:0] d5;
   logic [8:0] dout [3];
   logic dv [3], pe_o [3], se [3], bk [3], by [3];
   logic [1:0] st0, st1, st2;

   int tests = 0;
   int fails = 0;
   int vld_cnt0 = 0;
   int snap;

`ifdef UART_BRK_DET_EN
   localparam logic EXP_BRK = 1'b1;
`else
   localparam logic EXP_BRK = 1'b0;
`endif

   always #5 CLK = ~CLK;

   uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1)) u8 (
      .CLK(CLK), .RST(RST), .frm_start(fs[0]), .bit_vld(bv[0]), .sampled_bit(sb),
      .par_en(pen), .par_typ(ptyp), .data_out(d8a), .data_vld(dv[0]), .par_err(pe_o[0]),
      .stp_err(se[0]), .brk_det(bk[0]), .busy(by[0]), .state_dbg(st0));

   uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2)) u2 (
      .CLK(CLK), .RST(RST), .frm_start(fs[1]), .bit_vld(bv[1]), .sampled_bit(sb),
      .par_en(pen), .par_typ(ptyp), .data_out(d8b), .data_vld(dv[1]), .par_err(pe_o[1]),
      .stp_err(se[1]), .brk_det(bk[1]), .busy(by[1]), .state_dbg(st1));

   uart_rx_frame_check #(.DATA_WIDTH(5), .STOP_BITS(1)) u5 (
      .CLK(CLK), .RST(RST), .frm_start(fs[2]), .bit_vld(bv[2]), .sampled_bit(sb),
      .par_en(pen), .par_typ(ptyp), .data_out(d5), .data_vld(dv[2]), .par_err(pe_o[2]),
      .stp_err(se[2]), .brk_det(bk[2]), .busy(by[2]), .state_dbg(st2));

   assign dout[0] = {1'b0, d8a};
   assign dout[1] = {1'b0, d8b};
   assign dout[2] = {4'b0, d5};

   always @(negedge CLK) if (dv[0]) vld_cnt0++;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input int sel, input logic p_en, input logic p_typ);
      fs[sel] = 1'b1; pen = p_en; ptyp = p_typ;
      @(posedge CLK); #1;
      fs[sel] = 1'b0;
      chk("busy_after_start", 16'(by[sel]), 16'd1);
   endtask

   task automatic send_bit(input int sel, input logic b);
      bv[sel] = 1'b1; sb = b;
      @(posedge CLK); #1;
      bv[sel] = 1'b0;
   endtask

   task automatic send_bits(input int sel, input logic [8:0] d, input int nb);
      for (int i = 0; i < nb; i++) send_bit(sel, d[i]);
   endtask

   task automatic frame(input int sel, input logic [8:0] d, input int nb, input logic p_en,
                        input logic p_typ, input logic pbit, input logic s0, input logic s1,
                        input int ns);
      start(sel, p_en, p_typ);
      send_bits(sel, d, nb);
      if (p_en) send_bit(sel, pbit);
      send_bit(sel, s0);
      if (ns == 2) send_bit(sel, s1);
   endtask

   task automatic res(input int sel, input logic [8:0] d, input logic p, input logic s,
                      input logic b);
      chk("data_out", 16'(dout[sel]), 16'(d));
      chk("data_vld", 16'(dv[sel]), 16'd1);
      chk("par_err", 16'(pe_o[sel]), 16'(p));
      chk("stp_err", 16'(se[sel]), 16'(s));
      chk("brk_det", 16'(bk[sel]), 16'(b));
      chk("busy_commit", 16'(by[sel]), 16'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin fs[i] = 1'b0; bv[i] = 1'b0; end
      repeat (2) @(posedge CLK);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_data", 16'(dout[i]), 16'd0);
         chk("rst_vld", 16'(dv[i]), 16'd0);
         chk("rst_flags", 16'({pe_o[i], se[i], bk[i]}), 16'd0);
         chk("rst_busy", 16'(by[i]), 16'd0);
      end
      RST = 1'b1;
      @(posedge CLK); #1;

      // bit strobes while idle are ignored
      send_bit(0, 1'b1);
      send_bit(0, 1'b0);
      chk("idle_busy", 16'(by[0]), 16'd0);
      chk("idle_vld", 16'(dv[0]), 16'd0);

      frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      res(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      chk("vld_one_cycle", 16'(dv[0]), 16'd0);

      // parity: 0x07 has three ones
      frame(0, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
      res(0, 9'h007, 1'b0, 1'b0, 1'b0);
      frame(0, 9'h007, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      res(0, 9'h007, 1'b1, 1'b0, 1'b0);
      frame(0, 9'h007, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
      res(0, 9'h007, 1'b0, 1'b0, 1'b0);

      // two stop bits: no commit after the first one
      start(1, 1'b0, 1'b0);
      send_bits(1, 9'h03C, 8);
      send_bit(1, 1'b1);
      chk("stop2_first_vld", 16'(dv[1]), 16'd0);
      chk("stop2_first_busy", 16'(by[1]), 16'd1);
      send_bit(1, 1'b0);
      res(1, 9'h03C, 1'b0, 1'b1, 1'b0);
      frame(1, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
      res(1, 9'h03C, 1'b0, 1'b0, 1'b0);
      frame(1, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
      res(1, 9'h0C3, 1'b0, 1'b1, 1'b0);

      // abort after 4 bits; restart collides with a bit strobe that must be dropped
      @(posedge CLK); #1;
      start(0, 1'b0, 1'b0);
      send_bits(0, 9'h00B, 4);
      snap = vld_cnt0;
      chk("abort_hold_data", 16'(dout[0]), 16'h007);
      fs[0] = 1'b1; bv[0] = 1'b1; sb = 1'b1; pen = 1'b0; ptyp = 1'b0;
      @(posedge CLK); #1;
      fs[0] = 1'b0; bv[0] = 1'b0;
      chk("abort_busy", 16'(by[0]), 16'd1);
      send_bits(0, 9'h055, 8);
      send_bit(0, 1'b1);
      res(0, 9'h055, 1'b0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      chk("abort_vld_count", 16'(vld_cnt0 - snap), 16'd1);

      // break frame, then flags persist across frm_start until the next commit
      frame(0, 9'h000, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      res(0, 9'h000, 1'b0, 1'b1, EXP_BRK);
      start(0, 1'b0, 1'b0);
      chk("flags_hold_stp", 16'(se[0]), 16'd1);
      chk("flags_hold_brk", 16'(bk[0]), 16'(EXP_BRK));
      send_bits(0, 9'h0FF, 8);
      send_bit(0, 1'b1);
      res(0, 9'h0FF, 1'b0, 1'b0, 1'b0);

      // 5-bit instance, reset mid-frame
      frame(2, 9'h01F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      res(2, 9'h01F, 1'b0, 1'b0, 1'b0);
      start(2, 1'b1, 1'b0);
      send_bits(2, 9'h015, 3);
      RST = 1'b0;
      #1;
      chk("midrst_data", 16'(dout[2]), 16'd0);
      chk("midrst_vld", 16'(dv[2]), 16'd0);
      chk("midrst_flags", 16'({pe_o[2], se[2], bk[2]}), 16'd0);
      chk("midrst_busy", 16'(by[2]), 16'd0);
      @(posedge CLK); #3;
      RST = 1'b1;
      @(posedge CLK); #1;
      frame(2, 9'h00A, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      res(2, 9'h00A, 1'b0, 1'b0, 1'b0);

      repeat (2) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised receive-side frame checker for the UART RX path. It consumes the per-bit strobes from the RX bit sampler after the start bit has been validated. It deserialises the data bits and checks optional parity and a configurable number of stop bits. It presents one registered result per frame: data word, parity error, stop error and optional break indication. It replaces the single-bit stop checker in the RX path and sits between the sampler/start-check stage and the RX output register.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports (reset RST, asynchronous, active-low; clock CLK):
- CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- frm_start  in  1  one-cycle pulse: start bit validated; begins a new frame.
- bit_vld  in  1  one-cycle strobe per sampled bit after the start bit (data, parity, stop).
- sampled_bit  in  1  sampled line value, valid when bit_vld=1.
- par_en  in  1  parity bit present; latched at frm_start.
- par_typ  in  1  0 = even, 1 = odd; latched at frm_start.
- data_out  out  DATA_WIDTH  received word, LSB received first.
- data_vld  out  1  one-cycle pulse: frame result updated.
- par_err  out  1  parity mismatch in last completed frame.
- stp_err  out  1  any stop bit sampled 0 in last completed frame.
- brk_det  out  1  break detected in last completed frame (see Configuration).
- busy  out  1  high while state is not IDLE.

## Operation
- States: IDLE, DATA, PAR, STOP.
- IDLE: bit_vld ignored. On frm_start, latch par_en/par_typ, clear the bit counter, clear the running parity and enter DATA.
- DATA: each bit_vld shifts sampled_bit into the MSB of the shift register (shift right) and XORs it into the running parity. The counter increments on each bit_vld. After bit DATA_WIDTH-1, go to PAR if the latched par_en=1, else go to STOP.
- PAR: on bit_vld, the parity error is computed as running_parity XOR sampled_bit XOR latched par_typ. The result is 1 on mismatch. Then go to STOP.
- STOP: each bit_vld ANDs sampled_bit into a stop-OK accumulator. After STOP_BITS stop bits, commit the result and return to IDLE. With 2 stop bits, the block always waits for both bits, even if the first is 0.
- Commit: data_out, par_err, stp_err and brk_det load together and data_vld=1 for that one cycle. par_err is forced to 0 when the latched par_en=0.
- Flags hold their value until the next commit; they are not cleared at frm_start.
- Priority: frm_start beats bit_vld in any state. A frm_start outside IDLE aborts the current frame: no commit, outputs unchanged, and a new frame starts.
- frm_start and bit_vld in the same cycle: the bit is discarded.

## Timing
- Reset: state IDLE; data_out=0, data_vld=0, par_err=0, stp_err=0, brk_det=0, busy=0. Internal counter, parity and accumulators are 0.
- Reset asserted mid-frame returns the block to IDLE immediately with no commit.
- busy rises the cycle after frm_start.
- Commit latency: outputs update and data_vld is high in the cycle after the CLK edge that samples the last stop-bit strobe. busy falls in that same cycle.
- Back-to-back frames: frm_start is accepted in the data_vld cycle.
- Counter width is clog2(DATA_WIDTH)+1. The counter never wraps within a frame.

## Configuration
- UART_BRK_DET_EN defined: break detection is compiled in. brk_det=1 at commit when all data bits are 0, the parity bit is 0 (if enabled) and the first stop bit is 0. stp_err is also 1 in that case.
- UART_BRK_DET_EN undefined: brk_det is tied to 0 and no zero-detect logic is built. The port remains present.

## Test plan
- DATA_WIDTH=8, STOP_BITS=1, par_en=0; frame 0xA5, stop=1 -> data_out=0xA5, data_vld one cycle, par_err=0, stp_err=0.
- par_en=1, par_typ=0 (even); 0x07 with parity bit 1 -> par_err=0. Repeat with parity bit 0 -> par_err=1. Repeat with par_typ=1 and parity bit 0 -> par_err=0.
- STOP_BITS=2; 0x3C with stop bits 1,0 -> commit only after the second stop strobe, stp_err=1. Next frame with stop bits 1,1 -> stp_err=0.
- Abort: frm_start after 4 data bits, then full frame 0x55 -> exactly one data_vld, data_out=0x55.
- With UART_BRK_DET_EN: 0x00, parity bit 0 (par_en=1), stop=0 -> brk_det=1, stp_err=1. Without the macro, the same frame -> brk_det=0.
- DATA_WIDTH=5: frame 0x1F. Assert RST mid-frame -> all outputs 0, busy=0; the next frame 0x0A commits correctly.
